colour_blob_bbox: RTL and testbench
===================================

# colour_blob_bbox

Streaming colour-threshold and bounding-box stage directly downstream of the Qsys clocked-video output (vid_clk domain). Classifies each active RGB pixel against a per-channel range and accumulates a per-frame bounding box and match count. Re-emits the same video stream with the previous frame's box drawn on it, exporting the box coordinates for the navigation controller.

## Interface
- IMG_W, 640: active pixels per line; x coordinate saturates at IMG_W-1.
- IMG_H, 480: active lines per frame; y coordinate saturates at IMG_H-1.
- MIN_PIXELS, 16: minimum matched-pixel count for a frame's box to be declared valid.
- BOX_COLOUR, 24'hFF0000: RGB value written onto overlay pixels.

- clk  in  1  video clock (same clock as the clocked-video output).
- reset  in  1  synchronous, active-high reset.
- in_data  in  24  pixel {R[23:16], G[15:8], B[7:0]}.
- in_datavalid  in  1  active-pixel qualifier.
- in_h_sync  in  1  horizontal sync, active-high.
- in_v_sync  in  1  vertical sync, active-high.
- thr_lo  in  24  per-channel inclusive lower bound, same packing as in_data.
- thr_hi  in  24  per-channel inclusive upper bound.
- overlay_en  in  1  1 = draw overlay; 0 = pass video unmodified.
- out_data  out  24  delayed pixel, possibly overlaid.
- out_datavalid, out_h_sync, out_v_sync  out  1 each  inputs delayed to match out_data.
- bbox_x_min, bbox_x_max  out  11 each  last completed frame's box, columns.
- bbox_y_min, bbox_y_max  out  10 each  last completed frame's box, rows.
- pix_count  out  20  last completed frame's matched-pixel count, saturating at 20'hFFFFF.
- bbox_valid  out  1  last frame's pix_count >= MIN_PIXELS.
- frame_done  out  1  one-cycle pulse when bbox outputs update.

## Operation
- Reset: every output 0. x = y = 0. Accumulators at sentinels: acc_x_min = 11'h7FF, acc_y_min = 10'h3FF, acc_x_max = acc_y_max = 0, acc_count = 0.
- Coordinates:
  - x increments on each in_datavalid cycle, saturating at IMG_W-1.
  - A falling edge of in_datavalid (prev 1, now 0) clears x and increments y, saturating at IMG_H-1.
- Frame boundary: a rising edge of in_v_sync (prev 0, now 1) clears x and y.
- Match: in_datavalid and, for every channel c, thr_lo[c] <= in_data[c] <= thr_hi[c]. Comparison is unsigned 8-bit. thr_lo[c] > thr_hi[c] never matches.
- On match: update min/max of x and y with the current pixel coordinates; acc_count += 1, saturating.
- At the frame boundary:
  - bbox_* <= acc_*.
  - pix_count <= acc_count.
  - bbox_valid <= (acc_count >= MIN_PIXELS).
  - frame_done = 1 for exactly that cycle.
  - Accumulators return to sentinels.
  - A matched pixel in the same cycle is accumulated into the new frame.
- If bbox_valid = 0, bbox_* still carry the accumulator values, including sentinels when the count is 0.
- Overlay: an output pixel is replaced by BOX_COLOUR when all of the following hold:
  - overlay_en = 1
  - bbox_valid = 1
  - the pixel's datavalid = 1
  - the pixel lies on the box perimeter: (x == bbox_x_min or x == bbox_x_max) with bbox_y_min <= y <= bbox_y_max, or (y == bbox_y_min or y == bbox_y_max) with bbox_x_min <= x <= bbox_x_max.
- The overlay always uses the box registered at the last frame boundary. A box update mid-frame cannot occur.

## Timing
- Pipeline depth 2:
  - stage 1 registers the inputs, coordinates and match flag;
  - stage 2 registers out_* after the overlay mux.
- out_* equals the in_* values from 2 cycles earlier.
- Sync and datavalid relationships are preserved exactly. There is no backpressure.
- frame_done and the bbox_* update land 1 cycle after the clock edge that samples the v_sync rising edge.
- Reset asserted mid-frame: all state returns to reset values on the next edge. The partial frame is discarded and produces no frame_done.
- Threshold changes take effect on the next sampled pixel and may split a frame's classification. Software changes thresholds during vertical blank.

## Configuration
- BBOX_CROSSHAIR_EN:
  - Defined: the overlay also draws a crosshair at cx = (bbox_x_min + bbox_x_max) >> 1 and cy = (bbox_y_min + bbox_y_max) >> 1. The crosshair is the pixels with x == cx or y == cy, inside the box. The sum is computed at 12/11 bits, so there is no overflow. Same gating conditions as the perimeter.
  - Undefined: perimeter only; no centre logic is instantiated.

## Test plan
- 640x480 frame, thr_lo = 24'hC00000, thr_hi = 24'hFF3F3F, red patch x 100..149, y 200..239; next v_sync rising -> bbox 100/149/200/239, pix_count = 2000, bbox_valid = 1, frame_done pulses once.
- Same thresholds, 10 matching pixels -> pix_count = 10, bbox_valid = 0; next frame shows no overlay.
- Frame N has the box above; frame N+1 with overlay_en = 1 -> out_data = 24'hFF0000 at (100,200), (149,220), (120,239); out_data = in_data at (120,220). Every out_* equals in_* delayed 2 cycles.
- Reset pulsed at line 300 of a frame -> all outputs 0, no frame_done; the following full frame reports only that frame's pixels.
- thr_lo = 24'h000000, thr_hi = 24'hFFFFFF, full frame -> bbox 0/639/0/479, pix_count = 307200.
- With BBOX_CROSSHAIR_EN and box 100..149 x 200..239 -> overlay at (124,210) and (130,219); no overlay at (130,210).

Source files
------------

// File: rtl/colour_blob_bbox.sv
// Colour-threshold classifier with per-frame bounding box, match count and overlay of the previous frame's box.
// Define BBOX_CROSSHAIR_EN to also draw a crosshair through the box centre.
module colour_blob_bbox #(
  parameter int          IMG_W      = 640,
  parameter int          IMG_H      = 480,
  parameter int          MIN_PIXELS = 16,
  parameter logic [23:0] BOX_COLOUR = 24'hFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] in_data,
  input  logic        in_datavalid,
  input  logic        in_h_sync,
  input  logic        in_v_sync,
  input  logic [23:0] thr_lo,
  input  logic [23:0] thr_hi,
  input  logic        overlay_en,
  output logic [23:0] out_data,
  output logic        out_datavalid,
  output logic        out_h_sync,
  output logic        out_v_sync,
  output logic [10:0] bbox_x_min,
  output logic [10:0] bbox_x_max,
  output logic [9:0]  bbox_y_min,
  output logic [9:0]  bbox_y_max,
  output logic [19:0] pix_count,
  output logic        bbox_valid,
  output logic        frame_done
);

  localparam logic [10:0] X_LAST  = 11'(IMG_W - 1);
  localparam logic [9:0]  Y_LAST  = 10'(IMG_H - 1);
  localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;

  logic [23:0] s1_data;
  logic        s1_dv, s1_hs, s1_vs, s1_match, s1_frame;
  logic [10:0] s1_x;
  logic [9:0]  s1_y;

  logic [10:0] acc_x_min, acc_x_max;
  logic [9:0]  acc_y_min, acc_y_max;
  logic [19:0] acc_count;

  // Stage 1: coordinates, edge detection and classification
  logic        vs_rise, dv_fall, match;
  logic [2:0]  ch_ok;
  logic [10:0] cur_x, x_next;
  logic [9:0]  cur_y, y_next;

  always_comb begin
    vs_rise = in_v_sync & ~s1_vs;
    dv_fall = s1_dv & ~in_datavalid;
    cur_x   = vs_rise ? 11'd0 : x_cnt;
    cur_y   = vs_rise ? 10'd0 : y_cnt;
    for (int c = 0; c < 3; c++) begin
      ch_ok[c] = (in_data[8*c +: 8] >= thr_lo[8*c +: 8]) &&
                 (in_data[8*c +: 8] <= thr_hi[8*c +: 8]);
    end
    match  = in_datavalid & (&ch_ok);
    x_next = cur_x;
    y_next = cur_y;
    if (in_datavalid) begin
      if (cur_x != X_LAST) x_next = cur_x + 11'd1;
    end else if (dv_fall) begin
      x_next = 11'd0;
      // a frame start in the same cycle keeps y at the top line
      if (!vs_rise && cur_y != Y_LAST) y_next = cur_y + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      s1_data  <= '0;
      s1_dv    <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_match <= 1'b0;
      s1_frame <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      x_cnt    <= x_next;
      y_cnt    <= y_next;
      s1_data  <= in_data;
      s1_dv    <= in_datavalid;
      s1_hs    <= in_h_sync;
      s1_vs    <= in_v_sync;
      s1_match <= match;
      s1_frame <= vs_rise;
      s1_x     <= cur_x;
      s1_y     <= cur_y;
    end
  end

  // Stage 2: accumulate; a frame boundary restarts from sentinels before adding this pixel
  logic [10:0] base_x_min, base_x_max, nx_x_min, nx_x_max;
  logic [9:0]  base_y_min, base_y_max, nx_y_min, nx_y_max;
  logic [19:0] base_count, nx_count;

  always_comb begin
    base_x_min = s1_frame ? 11'h7FF : acc_x_min;
    base_x_max = s1_frame ? 11'h000 : acc_x_max;
    base_y_min = s1_frame ? 10'h3FF : acc_y_min;
    base_y_max = s1_frame ? 10'h000 : acc_y_max;
    base_count = s1_frame ? 20'h0   : acc_count;
    nx_x_min   = base_x_min;
    nx_x_max   = base_x_max;
    nx_y_min   = base_y_min;
    nx_y_max   = base_y_max;
    nx_count   = base_count;
    if (s1_match) begin
      if (s1_x < base_x_min) nx_x_min = s1_x;
      if (s1_x > base_x_max) nx_x_max = s1_x;
      if (s1_y < base_y_min) nx_y_min = s1_y;
      if (s1_y > base_y_max) nx_y_max = s1_y;
      if (base_count != 20'hFFFFF) nx_count = base_count + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_x_min  <= 11'h7FF;
      acc_x_max  <= '0;
      acc_y_min  <= 10'h3FF;
      acc_y_max  <= '0;
      acc_count  <= '0;
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
      pix_count  <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      acc_x_min  <= nx_x_min;
      acc_x_max  <= nx_x_max;
      acc_y_min  <= nx_y_min;
      acc_y_max  <= nx_y_max;
      acc_count  <= nx_count;
      frame_done <= s1_frame;
      if (s1_frame) begin
        bbox_x_min <= acc_x_min;
        bbox_x_max <= acc_x_max;
        bbox_y_min <= acc_y_min;
        bbox_y_max <= acc_y_max;
        pix_count  <= acc_count;
        bbox_valid <= (acc_count >= MIN_CNT);
      end
    end
  end

  // Overlay uses the box latched at the last boundary, which is stable for the whole frame
  logic x_in_box, y_in_box, on_perim, on_cross, draw;

`ifdef BBOX_CROSSHAIR_EN
  logic [11:0] cx_sum;
  logic [10:0] cy_sum;
  logic [10:0] cx;
  logic [9:0]  cy;
`endif

  always_comb begin
    x_in_box = (s1_x >= bbox_x_min) && (s1_x <= bbox_x_max);
    y_in_box = (s1_y >= bbox_y_min) && (s1_y <= bbox_y_max);
    on_perim = ((s1_x == bbox_x_min || s1_x == bbox_x_max) && y_in_box) ||
               ((s1_y == bbox_y_min || s1_y == bbox_y_max) && x_in_box);
`ifdef BBOX_CROSSHAIR_EN
    cx_sum   = {1'b0, bbox_x_min} + {1'b0, bbox_x_max};
    cy_sum   = {1'b0, bbox_y_min} + {1'b0, bbox_y_max};
    cx       = cx_sum[11:1];
    cy       = cy_sum[10:1];
    on_cross = (s1_x == cx || s1_y == cy) && x_in_box && y_in_box;
`else
    on_cross = 1'b0;
`endif
    draw = overlay_en & bbox_valid & s1_dv & (on_perim | on_cross);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data      <= '0;
      out_datavalid <= 1'b0;
      out_h_sync    <= 1'b0;
      out_v_sync    <= 1'b0;
    end else begin
      out_data      <= draw ? BOX_COLOUR : s1_data;
      out_datavalid <= s1_dv;
      out_h_sync    <= s1_hs;
      out_v_sync    <= s1_vs;
    end
  end

endmodule

// File: tb/tb_colour_blob_bbox.sv
// Directed bench for colour_blob_bbox on a reduced 32x24 image; honours BBOX_CROSSHAIR_EN.
module tb_colour_blob_bbox;

  localparam int W    = 32;
  localparam int H    = 24;
  localparam int MINP = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] in_data, thr_lo, thr_hi;
  logic        in_datavalid, in_h_sync, in_v_sync, overlay_en;
  logic [23:0] out_data;
  logic        out_datavalid, out_h_sync, out_v_sync;
  logic [10:0] bbox_x_min, bbox_x_max;
  logic [9:0]  bbox_y_min, bbox_y_max;
  logic [19:0] pix_count;
  logic        bbox_valid, frame_done;

  always #5 clk = ~clk;

  colour_blob_bbox #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(MINP), .BOX_COLOUR(24'hFF0000)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_datavalid(in_datavalid), .in_h_sync(in_h_sync), .in_v_sync(in_v_sync),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .overlay_en(overlay_en),
    .out_data(out_data), .out_datavalid(out_datavalid), .out_h_sync(out_h_sync), .out_v_sync(out_v_sync),
    .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max), .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
    .pix_count(pix_count), .bbox_valid(bbox_valid), .frame_done(frame_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // stimulus pattern and expected box currently drawn
  int          px0, px1, py0, py1;
  bit          fill_mode = 1'b0;
  logic [23:0] fill_val = 24'h0;
  bit          exp_valid = 1'b0;
  int          ex0, ex1, ey0, ey1;

  logic [23:0] h_d  [2];
  logic        h_dv [2];
  logic        h_hs [2];
  logic        h_vs [2];
  logic        h_ok [2];
  int          h_x  [2];
  int          h_y  [2];
  logic [23:0] obs [0:W-1][0:H-1];
  int          pipe_err = 0;
  int          fd_cnt = 0;
  int          fd_at = -1;
  int          fcyc = 0;

  function automatic logic [23:0] pix(int x, int y);
    if (fill_mode) return fill_val;
    if (x >= px0 && x <= px1 && y >= py0 && y <= py1)
      return ((x + y) % 2 == 1) ? 24'hC03F00 : 24'hFF003F;
    return ((x + y) % 2 == 1) ? 24'hBF0000 : 24'hC04000;
  endfunction

  function automatic bit on_box(int x, int y);
`ifdef BBOX_CROSSHAIR_EN
    int cx, cy;
`endif
    bit ix, iy, r;
    ix = (x >= ex0 && x <= ex1);
    iy = (y >= ey0 && y <= ey1);
    r  = ((x == ex0 || x == ex1) && iy) || ((y == ey0 || y == ey1) && ix);
`ifdef BBOX_CROSSHAIR_EN
    cx = (ex0 + ex1) / 2;
    cy = (ey0 + ey1) / 2;
    r  = r || ((x == cx || y == cy) && ix && iy);
`endif
    return r;
  endfunction

  task automatic cyc(input logic [23:0] d, input logic dv, input logic hs, input logic vs,
                     input int x, input int y);
    logic [23:0] e;
    @(negedge clk);
    if (frame_done) begin
      fd_cnt++;
      fd_at = fcyc;
    end
    if (h_ok[1]) begin
      e = h_d[1];
      if (overlay_en && exp_valid && h_dv[1] && on_box(h_x[1], h_y[1])) e = 24'hFF0000;
      if ({out_data, out_datavalid, out_h_sync, out_v_sync} !== {e, h_dv[1], h_hs[1], h_vs[1]})
        pipe_err++;
      if (h_dv[1]) obs[h_x[1]][h_y[1]] = out_data;
    end
    h_d[1] = h_d[0]; h_dv[1] = h_dv[0]; h_hs[1] = h_hs[0]; h_vs[1] = h_vs[0];
    h_ok[1] = h_ok[0]; h_x[1] = h_x[0]; h_y[1] = h_y[0];
    h_d[0] = d; h_dv[0] = dv; h_hs[0] = hs; h_vs[0] = vs; h_ok[0] = 1'b1;
    h_x[0] = (x > W - 1) ? W - 1 : x;
    h_y[0] = (y > H - 1) ? H - 1 : y;
    in_data = d; in_datavalid = dv; in_h_sync = hs; in_v_sync = vs;
    fcyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_data = '0; in_datavalid = 1'b0; in_h_sync = 1'b0; in_v_sync = 1'b0;
    @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_dv", out_datavalid, 0);
    check("rst_bbox_x_min", bbox_x_min, 0);
    check("rst_pix_count", pix_count, 0);
    check("rst_bbox_valid", bbox_valid, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    h_ok[0] = 1'b0;
    h_ok[1] = 1'b0;
    fd_cnt = 0;
  endtask

  task automatic vsync_phase();
    fcyc = 0;
    fd_cnt = 0;
    fd_at = -1;
    for (int i = 0; i < 6; i++) cyc(24'h0, 1'b0, 1'b0, i < 3, 0, 0);
  endtask

  task automatic report(input string t, input int xmin, input int xmax, input int ymin,
                        input int ymax, input int cnt, input int vld);
    check({t, "_fd_cnt"}, fd_cnt, 1);
    check({t, "_fd_at"}, fd_at, 2);
    check({t, "_x_min"}, bbox_x_min, xmin);
    check({t, "_x_max"}, bbox_x_max, xmax);
    check({t, "_y_min"}, bbox_y_min, ymin);
    check({t, "_y_max"}, bbox_y_max, ymax);
    check({t, "_count"}, pix_count, cnt);
    check({t, "_valid"}, bbox_valid, vld);
  endtask

  task automatic lines(input int nl, input int ppl, input int rst_line);
    for (int y = 0; y < nl; y++) begin
      if (y == rst_line) begin
        do_reset();
        return;
      end
      for (int x = 0; x < ppl; x++) cyc(pix(x, y), 1'b1, 1'b0, 1'b0, x, y);
      for (int i = 0; i < 4; i++) cyc(24'h0, 1'b0, i < 2, 1'b0, 0, 0);
    end
  endtask

  task automatic set_box(input int a, input int b, input int c, input int d, input bit v);
    ex0 = a; ex1 = b; ey0 = c; ey1 = d; exp_valid = v;
  endtask

  initial begin
    h_ok[0] = 1'b0; h_ok[1] = 1'b0;
    reset = 1'b1;
    in_data = '0; in_datavalid = 1'b0; in_h_sync = 1'b0; in_v_sync = 1'b0;
    thr_lo = 24'hC00000; thr_hi = 24'hFF3F3F; overlay_en = 1'b0;
    px0 = 10; px1 = 19; py0 = 5; py1 = 14;
    set_box(0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("init_out_data", out_data, 0);
    check("init_x_min", bbox_x_min, 0);
    check("init_y_min", bbox_y_min, 0);
    check("init_count", pix_count, 0);
    check("init_valid", bbox_valid, 0);
    check("init_frame_done", frame_done, 0);
    reset = 1'b0;

    // F0: 10x10 patch; boundary reports an empty accumulator
    vsync_phase();
    report("f0", 11'h7FF, 0, 10'h3FF, 0, 0, 0);
    lines(H, W, -1);
    check("f0_pipe", pipe_err, 0); pipe_err = 0;

    // F1: overlay of F0's box on the same patch
    overlay_en = 1'b1;
    vsync_phase();
    report("f1", 10, 19, 5, 14, 100, 1);
    set_box(10, 19, 5, 14, 1'b1);
    lines(H, W, -1);
    check("f1_pipe", pipe_err, 0); pipe_err = 0;
    check("f1_ovl_10_5", obs[10][5], 24'hFF0000);
    check("f1_ovl_19_10", obs[19][10], 24'hFF0000);
    check("f1_ovl_14_14", obs[14][14], 24'hFF0000);
    check("f1_pass_12_11", obs[12][11], pix(12, 11));
    check("f1_pass_9_5", obs[9][5], pix(9, 5));
`ifdef BBOX_CROSSHAIR_EN
    check("f1_cross_14_7", obs[14][7], 24'hFF0000);
    check("f1_cross_16_9", obs[16][9], 24'hFF0000);
`else
    check("f1_nocross_14_7", obs[14][7], pix(14, 7));
    check("f1_nocross_16_9", obs[16][9], pix(16, 9));
`endif

    // F2: only 10 matching pixels
    px0 = 3; px1 = 12; py0 = 2; py1 = 2;
    vsync_phase();
    report("f2", 10, 19, 5, 14, 100, 1);
    lines(H, W, -1);
    check("f2_pipe", pipe_err, 0); pipe_err = 0;

    // F3: box below threshold -> no overlay; reset mid-frame discards the partial frame
    px0 = 10; px1 = 19; py0 = 5; py1 = 14;
    vsync_phase();
    report("f3", 3, 12, 2, 2, 10, 0);
    set_box(3, 12, 2, 2, 1'b0);
    lines(H, W, 12);
    for (int i = 0; i < 10; i++) cyc(24'h0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("f3_no_frame_done", fd_cnt, 0);
    check("f3_pipe", pipe_err, 0); pipe_err = 0;
    check("f3_nooverlay_3_2", obs[3][2], pix(3, 2));
    check("f3_nooverlay_10_5", obs[10][5], pix(10, 5));

    // F4: corner patch of exactly MIN_PIXELS; boundary shows sentinels after the reset
    px0 = 28; px1 = 31; py0 = 20; py1 = 23;
    vsync_phase();
    report("f4", 11'h7FF, 0, 10'h3FF, 0, 0, 0);
    lines(H, W, -1);
    check("f4_pipe", pipe_err, 0); pipe_err = 0;

    // F5: match-all thresholds, oversize frame saturates coordinates
    thr_lo = 24'h000000; thr_hi = 24'hFFFFFF;
    vsync_phase();
    report("f5", 28, 31, 20, 23, 16, 1);
    set_box(28, 31, 20, 23, 1'b1);
    lines(30, 40, -1);
    check("f5_pipe", pipe_err, 0); pipe_err = 0;
    check("f5_ovl_31_20", obs[31][20], 24'hFF0000);
    check("f5_pass_30_22", obs[30][22], pix(30, 22));

    // F6: inverted range never matches
    thr_lo = 24'h808080; thr_hi = 24'h7FFFFF;
    fill_mode = 1'b1; fill_val = 24'h808080;
    vsync_phase();
    report("f6", 0, 31, 0, 23, 1200, 1);
    set_box(0, 31, 0, 23, 1'b1);
    lines(H, W, -1);
    check("f6_pipe", pipe_err, 0); pipe_err = 0;
    check("f6_ovl_0_0", obs[0][0], 24'hFF0000);
    check("f6_pass_5_5", obs[5][5], 24'h808080);

    vsync_phase();
    report("f7", 11'h7FF, 0, 10'h3FF, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
